// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2, constraint-length-3 convolutional encoder with
// valid/ready handshakes on both sides and a single registered output stage.
// Optional feature macro: CONV_ENC_TAIL_EN. When it is defined, two zero tail
// symbols flush the state after each frame. Without it, the state is cleared
// on the frame's last bit.
module conv_encoder #(
  parameter logic [2:0] G0 = 3'b111,  // sym_out[1]: {u, s[1], s[0]} taps
  parameter logic [2:0] G1 = 3'b101   // sym_out[0]
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       din_last,
  output logic       din_ready,
  output logic [1:0] sym_out,
  output logic       sym_valid,
  output logic       sym_last,
  input  logic       sym_ready,
  output logic       busy
);

`ifdef CONV_ENC_TAIL_EN
  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;
  logic tail_cnt;  // 0: first tail symbol, 1: second (final) tail symbol
`else
  typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

  state_t     state, state_nxt;
  logic [1:0] s;         // s[1] = most recent past bit
  logic       out_free;  // output register can take a new symbol this cycle
  logic       accept;
  logic       gen;       // a symbol is produced this cycle
  logic       u;         // encoder input bit for the produced symbol
  logic       last_gen;  // produced symbol ends the frame
  logic [2:0] w;
  logic       c0, c1;

  assign busy = (state != IDLE);
  assign w    = {u, s};
  assign c0   = ^(w & G0);
  assign c1   = ^(w & G1);

  // Handshake decode and next-state / symbol-generation control
  always_comb begin
    state_nxt = state;
    gen       = 1'b0;
    u         = 1'b0;
    last_gen  = 1'b0;
    out_free  = !sym_valid || sym_ready;
    din_ready = !rst && ((state == IDLE) || (state == DATA)) && out_free;
    accept    = din_valid && din_ready;
    case (state)
      IDLE, DATA: begin
        if (accept) begin
          gen = 1'b1;
          u   = din;
`ifdef CONV_ENC_TAIL_EN
          state_nxt = din_last ? TAIL : DATA;
`else
          last_gen  = din_last;
          state_nxt = din_last ? IDLE : DATA;
`endif
        end
      end
`ifdef CONV_ENC_TAIL_EN
      TAIL: begin
        // Zero input bits flush the state; the second one closes the frame.
        if (out_free) begin
          gen      = 1'b1;
          last_gen = tail_cnt;
          if (tail_cnt) state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // State register, shift register and output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s         <= 2'b00;
      sym_out   <= 2'b00;
      sym_valid <= 1'b0;
      sym_last  <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
      tail_cnt  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (gen) begin
        sym_out   <= {c0, c1};
        sym_valid <= 1'b1;
        sym_last  <= last_gen;
        // Frame end leaves s at 00 so the next frame starts clean.
        s         <= last_gen ? 2'b00 : {u, s[1]};
      end else if (sym_ready) begin
        sym_valid <= 1'b0;
        sym_last  <= 1'b0;
      end
`ifdef CONV_ENC_TAIL_EN
      if (state == TAIL && gen) tail_cnt <= ~tail_cnt;
`endif
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: directed and randomized checks of conv_encoder against a
// frame-level convolution model (bits of the current frame kept in a queue).
// Honours CONV_ENC_TAIL_EN the same way the design does.
module tb_conv_encoder;
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  logic       clk = 1'b0;
  logic       rst, din, din_valid, din_last, din_ready;
  logic [1:0] sym_out;
  logic       sym_valid, sym_last, sym_ready, busy;

  int         n_pass = 0;
  int         n_tot  = 0;
  logic [2:0] expq[$];   // expected {last, sym} in output order
  logic       hist[$];   // bits of the current frame, oldest first
  logic [2:0] got[$];    // consumed {last, sym}, for directed comparisons
  logic [2:0] ref_q[$];

  conv_encoder #(.G0(G0), .G1(G1)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_last(din_last), .din_ready(din_ready), .sym_out(sym_out),
    .sym_valid(sym_valid), .sym_last(sym_last), .sym_ready(sym_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Output symbol for input u given the two previous frame bits p1 (newest), p2.
  function automatic logic [1:0] code(input logic u, input logic p1, input logic p2);
    logic a, b;
    a = (u & G0[2]) ^ (p1 & G0[1]) ^ (p2 & G0[0]);
    b = (u & G1[2]) ^ (p1 & G1[1]) ^ (p2 & G1[0]);
    return {a, b};
  endfunction

  task automatic model_accept(input logic u, input logic l);
    logic p1, p2;
    p1 = (hist.size() > 0) ? hist[hist.size()-1] : 1'b0;
    p2 = (hist.size() > 1) ? hist[hist.size()-2] : 1'b0;
`ifdef CONV_ENC_TAIL_EN
    expq.push_back({1'b0, code(u, p1, p2)});
    if (l) begin
      expq.push_back({1'b0, code(1'b0, u, p1)});
      expq.push_back({1'b1, code(1'b0, 1'b0, u)});
    end
`else
    expq.push_back({l, code(u, p1, p2)});
`endif
    hist.push_back(u);
    if (l) hist.delete();
  endtask

  task automatic consume();
    logic [2:0] e;
    if (expq.size() == 0) chk("unexpected_sym", 32'(expq.size()), 32'd1);
    else begin
      e = expq.pop_front();
      chk("sym_out", 32'(sym_out), 32'(e[1:0]));
      chk("sym_last", 32'(sym_last), 32'(e[2]));
    end
    got.push_back({sym_last, sym_out});
  endtask

  // One clock cycle: drive, sample at the falling edge, advance.
  task automatic cyc(input logic v, d, l, r, output logic acc, output logic lastc);
    din_valid = v; din = d; din_last = l; sym_ready = r;
    @(negedge clk);
    acc   = v && din_ready;
    lastc = sym_valid && r && sym_last;
    if (acc) model_accept(d, l);
    if (sym_valid && r) consume();
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input logic d, input logic l, input logic r);
    logic acc, lc;
    int n = 0;
    do begin cyc(1'b1, d, l, r, acc, lc); n++; end while (!acc && n < 20);
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    logic acc, lc;
    int n = 0;
    while ((expq.size() != 0 || sym_valid) && n < 30) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, acc, lc); n++;
    end
    chk("drain_queue", 32'(expq.size()), 32'd0);
    chk("drain_valid", 32'(sym_valid), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; din_valid = 1'b0; din = 1'b0; din_last = 1'b0; sym_ready = 1'b0;
    @(negedge clk);
    chk("rst_din_ready", 32'(din_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    expq.delete(); hist.delete();
    chk("rst_sym_valid", 32'(sym_valid), 32'd0);
    chk("rst_sym_last", 32'(sym_last), 32'd0);
    chk("rst_sym_out", 32'(sym_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  task automatic cmp_got(input string tag);
    chk({tag, "_len"}, 32'(got.size()), 32'(ref_q.size()));
    for (int i = 0; i < got.size() && i < ref_q.size(); i++)
      chk(tag, 32'(got[i]), 32'(ref_q[i]));
  endtask

  initial begin
    logic acc, lc;
    logic [1:0] held;
    int n;
    do_reset();

    // Frame 1,0,1,1 at full throughput
    got.delete();
    send_bit(1, 0, 1); send_bit(0, 0, 1); send_bit(1, 0, 1); send_bit(1, 1, 1);
    drain();
`ifdef CONV_ENC_TAIL_EN
    ref_q = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
`else
    ref_q = '{3'b011, 3'b010, 3'b000, 3'b101};
`endif
    cmp_got("frame_1011");

    // Single-bit frames
    got.delete(); send_bit(0, 1, 1); drain();
`ifdef CONV_ENC_TAIL_EN
    ref_q = '{3'b000, 3'b000, 3'b100};
`else
    ref_q = '{3'b100};
`endif
    cmp_got("single_0");
    got.delete(); send_bit(1, 1, 1); drain();
`ifdef CONV_ENC_TAIL_EN
    ref_q = '{3'b011, 3'b010, 3'b111};
`else
    ref_q = '{3'b111};
`endif
    cmp_got("single_1");

    // Downstream stall for 3 cycles with a bit pending on the input
    got.delete();
    send_bit(1, 0, 1);
    held = sym_out;
    for (int i = 0; i < 3; i++) begin
      din_valid = 1'b1; din = 1'b0; din_last = 1'b0; sym_ready = 1'b0;
      @(negedge clk);
      chk("stall_din_ready", 32'(din_ready), 32'd0);
      chk("stall_valid", 32'(sym_valid), 32'd1);
      chk("stall_sym_hold", 32'(sym_out), 32'(held));
      chk("stall_sym_model", 32'(sym_out), 32'(expq[0][1:0]));
      @(posedge clk); #1;
    end
    send_bit(0, 0, 1); send_bit(1, 0, 1); send_bit(1, 1, 1);
    drain();
`ifdef CONV_ENC_TAIL_EN
    ref_q = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
`else
    ref_q = '{3'b011, 3'b010, 3'b000, 3'b101};
`endif
    cmp_got("stall_frame");

    // Reset in the middle of a frame, then a fresh frame from state 00
    send_bit(1, 0, 1); send_bit(0, 0, 1);
    do_reset();
    got.delete(); send_bit(1, 1, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, acc, lc);
    chk("post_rst_first_sym", 32'(got[0][1:0]), 32'd3);
    drain();

    // Back-to-back frames: next frame's first bit taken with the last symbol
    send_bit(1, 1, 1);
    n = 0;
    do begin cyc(1'b1, 1'b1, 1'b1, 1'b1, acc, lc); n++; end while (!acc && n < 20);
    chk("b2b_accept", 32'(acc), 32'd1);
    chk("b2b_with_last", 32'(lc), 32'd1);
    chk("b2b_next_valid", 32'(sym_valid), 32'd1);
    drain();

    // Randomized traffic with random gaps, frame lengths and back-pressure
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0), acc, lc);
    // close any open frame, then flush
    if (hist.size() != 0) send_bit(0, 1, 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
- REQ-001 SHALL have parameter G0, default 3'b111: generator for sym_out[1]; bit2 taps the current input, bit1 taps s[1], bit0 taps s[0].
- REQ-002 SHALL have parameter G1, default 3'b101: generator for sym_out[0], same tap order as G0.
- REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
- REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
- REQ-005 SHALL have port din, input, 1 bit: information bit.
- REQ-006 SHALL have port din_valid, input, 1 bit: din is valid.
- REQ-007 SHALL have port din_last, input, 1 bit: din is the last bit of the frame.
- REQ-008 SHALL have port din_ready, output, 1 bit: encoder accepts din this cycle.
- REQ-009 SHALL have port sym_out, output, 2 bits: coded symbol {c0,c1}; this matches the branch labels 2'b00/2'b11 the decoder BMC uses for input 0/1 from state 00.
- REQ-010 SHALL have port sym_valid, output, 1 bit: sym_out is valid.
- REQ-011 SHALL have port sym_last, output, 1 bit: final symbol of the frame.
- REQ-012 SHALL have port sym_ready, input, 1 bit: downstream accepts the symbol.
- REQ-013 SHALL have port busy, output, 1 bit: high while the FSM is not in IDLE.

Function
- REQ-014 SHALL hold a 2-bit state s[1:0], with s[1] the most recent past bit; encoder word w = {u, s[1], s[0]}.
- REQ-015 SHALL compute c0 = XOR-reduce(w & G0) and c1 = XOR-reduce(w & G1); sym_out = {c0, c1}.
- REQ-016 SHALL update s <= {u, s[1]} on each symbol it generates.
- REQ-017 SHALL register symbols in one output stage: a bit accepted in cycle N gives sym_valid in cycle N+1.
- REQ-018 SHALL accept input only on din_valid && din_ready.
- REQ-019 SHALL drive din_ready = (state is IDLE or DATA) && (!sym_valid || sym_ready).
- REQ-020 SHALL hold sym_out, sym_valid and sym_last stable while sym_valid && !sym_ready.
- REQ-021 SHALL allow full throughput of one symbol per cycle when sym_ready stays high.
- REQ-022 SHALL implement FSM states IDLE, DATA and TAIL:
  - IDLE->DATA on accepting a bit with din_last=0.
  - IDLE or DATA -> TAIL on accepting a bit with din_last=1.
  - DATA stays in DATA on accepting a bit with din_last=0.
- REQ-023 SHALL hold din_ready low in TAIL and generate exactly 2 symbols with u=0, each issued when the output stage is free.
- REQ-024 SHALL assert sym_last only on the second tail symbol, then go to IDLE with s = 2'b00.
- REQ-025 SHALL allow a single-bit frame (din_last on the first bit), producing 1 data symbol plus 2 tail symbols.
- REQ-026 SHALL allow a new frame's first bit in the same cycle the previous sym_last is consumed, if din_ready is high.
- REQ-027 SHALL ignore din and din_last when din_valid is low.

Reset
- REQ-028 SHALL, while rst=1 at a clock edge, set FSM=IDLE, s=2'b00, sym_out=2'b00, sym_valid=0, sym_last=0 and busy=0.
- REQ-029 SHALL hold din_ready=0 during the reset cycle.
- REQ-030 SHALL, on reset mid-frame or mid-tail, discard any pending symbol and start the next bit from state 00.

Configuration
- REQ-031 SHALL, with CONV_ENC_TAIL_EN defined, apply zero-tail termination as in REQ-023/REQ-024.
- REQ-032 SHALL, without CONV_ENC_TAIL_EN:
  - omit the TAIL state;
  - assert sym_last on the symbol of the din_last bit;
  - clear s to 2'b00 when that bit is accepted, so the next frame starts from 00.

Verification
- REQ-033 Bits 1,0,1,1 (last on 4th), sym_ready=1, TAIL_EN defined -> symbols 11,10,00,01,01,11; sym_last on the 6th only; busy low after.
- REQ-034 Same stimulus, TAIL_EN undefined -> symbols 11,10,00,01; sym_last on the 4th; next frame bit 1 -> 11.
- REQ-035 Single bit 0 with last -> 00,00,00 with sym_last on the 3rd; bit 1 with last -> 11,10,11.
- REQ-036 sym_ready held low 3 cycles while sym_valid -> sym_out stable, din_ready=0, no bit lost; the sequence matches REQ-033.
- REQ-037 rst pulsed after the 2nd bit of REQ-033 -> sym_valid=0 next cycle; a new frame with bit 1 -> 11.
- REQ-038 Back-to-back frames, 2nd frame's first bit presented while the 1st frame's sym_last is consumed -> accepted that cycle; the 2nd frame's first symbol follows next cycle.
